// File: rtl/clock_pkg.sv
// Shared definitions for the multi-alarm clock: FSM states, mode codes,
// time-field limits and the wrap-around increment helpers.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } alarm_state_t;

   localparam logic [1:0] MODE_RUN       = 2'b00;
   localparam logic [1:0] MODE_SET_ALARM = 2'b01;
   localparam logic [1:0] MODE_SET_TIME  = 2'b10;
   localparam logic [1:0] MODE_ARMED     = 2'b11;

   localparam logic [5:0] SEC_MAX = 6'd59;
   localparam logic [5:0] MIN_MAX = 6'd59;

   // Minutes/seconds wrap 59 -> 0 with no carry out.
   function automatic logic [5:0] min_inc(input logic [5:0] m);
      return (m == MIN_MAX) ? 6'd0 : m + 6'd1;
   endfunction

   // Hours wrap 23 -> 0 in 24-hour mode, 12 -> 1 (never 0) in 12-hour mode.
   function automatic logic [4:0] hour_inc(input logic [4:0] h, input logic h24);
      if (h24)
         return (h == 5'd23) ? 5'd0 : h + 5'd1;
      else
         return (h == 5'd12) ? 5'd1 : h + 5'd1;
   endfunction

endpackage

// File: rtl/binarytoBCD.sv
// Binary minutes/hours to two BCD digits each, purely combinational.
module binarytoBCD (
   input  logic [5:0] minutes,
   input  logic [4:0] hours,
   output logic [3:0] min_LSB,
   output logic [3:0] min_MSB,
   output logic [3:0] hr_LSB,
   output logic [3:0] hr_MSB
);

   // Split each value into tens and units digits.
   always_comb begin
      min_MSB = 4'(minutes / 6'd10);
      min_LSB = 4'(minutes % 6'd10);
      hr_MSB  = 4'(hours / 5'd10);
      hr_LSB  = 4'(hours % 5'd10);
   end

endmodule

// File: rtl/multi_alarm_clock.sv
// Time-of-day clock with a parameterised bank of alarms, snooze and
// 12/24-hour BCD display. Single clock domain, synchronous clear.
module multi_alarm_clock
   import clock_pkg::*;
#(
   parameter int TICK_DIV    = 1_666_666,
   parameter int NUM_ALARMS  = 4,
   parameter int HOUR24      = 0,
   parameter int RING_SECS   = 5,
   parameter int SNOOZE_MINS = 5,
   localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic [1:0]            mode,
   input  logic [SEL_W-1:0]      alarm_sel,
   input  logic                  min_up,
   input  logic                  hour_up,
   input  logic [NUM_ALARMS-1:0] alarm_en,
   input  logic                  snooze,
   output logic                  alarm,
   output logic [SEL_W-1:0]      alarm_idx,
   output logic [3:0]            min_LSB,
   output logic [3:0]            min_MSB,
   output logic [3:0]            hr_LSB,
   output logic [3:0]            hr_MSB,
   output logic                  sec_tick
);

   localparam int         PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int         RW     = (RING_SECS > 0) ? $clog2(RING_SECS + 1) : 1;
   localparam logic       H24    = (HOUR24 != 0);
   localparam logic [4:0] HR_RST = H24 ? 5'd0 : 5'd12;

   logic [PW-1:0] presc;
   logic [5:0]    sec, min;
   logic [4:0]    hr;
   logic [5:0]    alm_min [NUM_ALARMS];
   logic [4:0]    alm_hr  [NUM_ALARMS];

   logic min_up_p0, min_up_p1, hour_up_p0, hour_up_p1, snooze_p0, snooze_p1;
   logic min_edge, hour_edge, snooze_edge;
   logic run, tick, minute_boundary, sel_ok;

   logic [5:0] sec_nx, min_nx;
   logic [4:0] hr_nx;
   logic       hit;
   logic [SEL_W-1:0] hit_idx;

   logic [6:0] wk_sum;
   logic [5:0] wake_min_nx, wake_min;
   logic [4:0] wake_hr_nx, wake_hr;

   alarm_state_t   state;
   logic [RW-1:0]  ring_cnt;

   logic [5:0] disp_min;
   logic [4:0] disp_hr;

   assign run             = (mode == MODE_RUN) || (mode == MODE_ARMED);
   assign tick            = run && (presc == PW'(TICK_DIV - 1));
   assign minute_boundary = tick && (sec == SEC_MAX);
   assign sec_tick        = tick;
   assign min_edge        = min_up_p0 & ~min_up_p1;
   assign hour_edge       = hour_up_p0 & ~hour_up_p1;
   assign snooze_edge     = snooze_p0 & ~snooze_p1;
   assign sel_ok          = (int'(alarm_sel) < NUM_ALARMS);

   // Register the push-button levels twice; a rising edge is one cycle of p0 & ~p1.
   always_ff @(posedge clk) begin
      if (clr) begin
         min_up_p0  <= 1'b0;
         min_up_p1  <= 1'b0;
         hour_up_p0 <= 1'b0;
         hour_up_p1 <= 1'b0;
         snooze_p0  <= 1'b0;
         snooze_p1  <= 1'b0;
      end else begin
         min_up_p0  <= min_up;
         min_up_p1  <= min_up_p0;
         hour_up_p0 <= hour_up;
         hour_up_p1 <= hour_up_p0;
         snooze_p0  <= snooze;
         snooze_p1  <= snooze_p0;
      end
   end

   // One-second prescaler; frozen at zero while editing so time cannot drift.
   always_ff @(posedge clk) begin
      if (clr || !run || tick)
         presc <= '0;
      else
         presc <= presc + PW'(1);
   end

   // Time value after the current tick, with seconds->minutes->hours carry.
   always_comb begin
      sec_nx = sec;
      min_nx = min;
      hr_nx  = hr;
      if (sec == SEC_MAX) begin
         sec_nx = 6'd0;
         min_nx = min_inc(min);
         if (min == MIN_MAX)
            hr_nx = hour_inc(hr, H24);
      end else begin
         sec_nx = sec + 6'd1;
      end
   end

   // Timekeeping: advance on ticks, or manual set in set-time mode (no carry).
   always_ff @(posedge clk) begin
      if (clr) begin
         sec <= 6'd0;
         min <= 6'd0;
         hr  <= HR_RST;
      end else if (run) begin
         if (tick) begin
            sec <= sec_nx;
            min <= min_nx;
            hr  <= hr_nx;
         end
      end else if (mode == MODE_SET_TIME) begin
         if (min_edge) begin
            min <= min_inc(min);
            sec <= 6'd0;
         end
         if (hour_edge)
            hr <= hour_inc(hr, H24);
      end
   end

   // Alarm register bank; only the selected entry is edited in set-alarm mode.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            alm_min[i] <= 6'd0;
            alm_hr[i]  <= HR_RST;
         end
      end else if (mode == MODE_SET_ALARM && sel_ok) begin
         if (min_edge)
            alm_min[alarm_sel] <= min_inc(alm_min[alarm_sel]);
         if (hour_edge)
            alm_hr[alarm_sel] <= hour_inc(alm_hr[alarm_sel], H24);
      end
   end

   // Lowest-index enabled alarm equal to the time about to be shown.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (alarm_en[i] && alm_hr[i] == hr_nx && alm_min[i] == min_nx) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   // Snooze wake time: now + SNOOZE_MINS, carrying into the hour and day.
   always_comb begin
      wk_sum = {1'b0, min} + 7'(SNOOZE_MINS % 60);
      if (wk_sum > 7'd59) begin
         wake_min_nx = 6'(wk_sum - 7'd60);
         wake_hr_nx  = hour_inc(hr, H24);
      end else begin
         wake_min_nx = wk_sum[5:0];
         wake_hr_nx  = hr;
      end
   end

   // Alarm FSM with registered ring output and latched alarm index.
   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= ST_IDLE;
         alarm     <= 1'b0;
         alarm_idx <= '0;
         ring_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mode == MODE_ARMED && minute_boundary && hit) begin
                  state     <= ST_RING;
                  alarm     <= 1'b1;
                  alarm_idx <= hit_idx;
                  ring_cnt  <= '0;
               end
            end
            ST_RING: begin
               if (mode != MODE_ARMED || !alarm_en[alarm_idx]) begin
                  state <= ST_IDLE;
                  alarm <= 1'b0;
               end else if (snooze_edge) begin
                  state    <= ST_SNOOZE;
                  alarm    <= 1'b0;
                  wake_min <= wake_min_nx;
                  wake_hr  <= wake_hr_nx;
               end else if (tick) begin
                  if (ring_cnt == RW'(RING_SECS - 1)) begin
                     state <= ST_IDLE;
                     alarm <= 1'b0;
                  end else begin
                     ring_cnt <= ring_cnt + RW'(1);
                  end
               end
            end
            ST_SNOOZE: begin
               if (mode != MODE_ARMED || !alarm_en[alarm_idx]) begin
                  state <= ST_IDLE;
                  alarm <= 1'b0;
               end else if (minute_boundary && hr_nx == wake_hr && min_nx == wake_min) begin
                  state    <= ST_RING;
                  alarm    <= 1'b1;
                  ring_cnt <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               alarm <= 1'b0;
            end
         endcase
      end
   end

   // Display source: selected alarm while editing alarms, otherwise the time.
   always_comb begin
      disp_min = min;
      disp_hr  = hr;
      if (mode == MODE_SET_ALARM && sel_ok) begin
         disp_min = alm_min[alarm_sel];
         disp_hr  = alm_hr[alarm_sel];
      end
   end

   binarytoBCD u_bcd (
      .minutes (disp_min),
      .hours   (disp_hr),
      .min_LSB (min_LSB),
      .min_MSB (min_MSB),
      .hr_LSB  (hr_LSB),
      .hr_MSB  (hr_MSB)
   );

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Bench for multi_alarm_clock: a 12-hour and a 24-hour instance share all
// inputs; a seconds-of-day model predicts both every cycle, and directed
// scenarios add literal checks on the interesting moments.
module tb_multi_alarm_clock;

   localparam int NA = 4;
   localparam int TD = 4;
   localparam int RS = 5;
   localparam int SN = 5;

   logic       clk = 1'b0;
   logic       clr, min_up, hour_up, snooze;
   logic [1:0] mode;
   logic [1:0] alarm_sel;
   logic [3:0] alarm_en;

   logic       alarm12, tick12, alarm24, tick24;
   logic [1:0] idx12, idx24;
   logic [3:0] ml12, mm12, hl12, hm12, ml24, mm24, hl24, hm24;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   multi_alarm_clock #(.TICK_DIV(TD), .NUM_ALARMS(NA), .HOUR24(0),
                       .RING_SECS(RS), .SNOOZE_MINS(SN)) dut12 (
      .clk(clk), .clr(clr), .mode(mode), .alarm_sel(alarm_sel),
      .min_up(min_up), .hour_up(hour_up), .alarm_en(alarm_en), .snooze(snooze),
      .alarm(alarm12), .alarm_idx(idx12), .min_LSB(ml12), .min_MSB(mm12),
      .hr_LSB(hl12), .hr_MSB(hm12), .sec_tick(tick12));

   multi_alarm_clock #(.TICK_DIV(TD), .NUM_ALARMS(NA), .HOUR24(1),
                       .RING_SECS(RS), .SNOOZE_MINS(SN)) dut24 (
      .clk(clk), .clr(clr), .mode(mode), .alarm_sel(alarm_sel),
      .min_up(min_up), .hour_up(hour_up), .alarm_en(alarm_en), .snooze(snooze),
      .alarm(alarm24), .alarm_idx(idx24), .min_LSB(ml24), .min_MSB(mm24),
      .hr_LSB(hl24), .hr_MSB(hm24), .sec_tick(tick24));

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Time is seconds since the start of the display period (12 h or 24 h);
   // alarms and wake time are minutes within that period.
   int  t   [2];
   int  am  [2][NA];
   int  st  [2];          // 0 idle, 1 ringing, 2 snoozed
   int  rc  [2];
   int  wk  [2];
   int  idx [2];
   bit  alm [2];
   int  pc;
   bit  ms1, ms2, hs1, hs2, ss1, ss2;
   bit  chk_on = 1'b0;
   bit  m_run, m_tick, m_me, m_he, m_se, bnd, found;
   int  nt, per, mi, hh;

   function automatic int period_min(int k);
      return (k == 0) ? 720 : 1440;
   endfunction

   always @(posedge clk) begin
      if (clr) begin
         pc = 0;
         for (int k = 0; k < 2; k++) begin
            t[k] = 0; st[k] = 0; rc[k] = 0; idx[k] = 0; alm[k] = 1'b0; wk[k] = 0;
            for (int i = 0; i < NA; i++) am[k][i] = 0;
         end
         ms1 = 0; ms2 = 0; hs1 = 0; hs2 = 0; ss1 = 0; ss2 = 0;
         chk_on = 1'b1;
      end else begin
         m_run  = (mode == 2'b00) || (mode == 2'b11);
         m_tick = m_run && (pc == TD - 1);
         m_me   = ms1 && !ms2;
         m_he   = hs1 && !hs2;
         m_se   = ss1 && !ss2;
         for (int k = 0; k < 2; k++) begin
            per = period_min(k);
            nt  = m_tick ? (t[k] + 1) % (per * 60) : t[k];
            bnd = m_tick && (nt % 60 == 0);
            if (st[k] == 0) begin
               if (mode == 2'b11 && bnd) begin
                  found = 1'b0;
                  for (int i = 0; i < NA; i++)
                     if (!found && alarm_en[i] && am[k][i] == nt / 60) begin
                        found = 1'b1; idx[k] = i;
                     end
                  if (found) begin st[k] = 1; alm[k] = 1'b1; rc[k] = 0; end
               end
            end else if (mode != 2'b11 || !alarm_en[idx[k]]) begin
               st[k] = 0; alm[k] = 1'b0;
            end else if (st[k] == 1) begin
               if (m_se) begin
                  st[k] = 2; alm[k] = 1'b0; wk[k] = (t[k] / 60 + SN) % per;
               end else if (m_tick) begin
                  rc[k]++;
                  if (rc[k] == RS) begin st[k] = 0; alm[k] = 1'b0; end
               end
            end else begin
               if (bnd && nt / 60 == wk[k]) begin st[k] = 1; alm[k] = 1'b1; rc[k] = 0; end
            end
            if (m_run) t[k] = nt;
            if (mode == 2'b10) begin
               if (m_me) begin
                  hh = t[k] / 3600; mi = (t[k] / 60) % 60;
                  t[k] = hh * 3600 + ((mi + 1) % 60) * 60;
               end
               if (m_he) t[k] = (t[k] + 3600) % (per * 60);
            end
            if (mode == 2'b01) begin
               if (m_me) am[k][alarm_sel] = (am[k][alarm_sel] / 60) * 60 + ((am[k][alarm_sel] % 60) + 1) % 60;
               if (m_he) am[k][alarm_sel] = (am[k][alarm_sel] + 60) % per;
            end
         end
         if (!m_run || m_tick) pc = 0; else pc++;
         ms2 = ms1; ms1 = min_up;
         hs2 = hs1; hs1 = hour_up;
         ss2 = ss1; ss1 = snooze;
      end
   end

   function automatic int disp_src(int k);
      if (mode == 2'b01) return am[k][alarm_sel] * 60;
      return t[k];
   endfunction

   function automatic int exp_hr(int k);
      int h;
      h = disp_src(k) / 3600;
      if (k == 0 && h == 0) h = 12;
      return h;
   endfunction

   function automatic int exp_min(int k);
      return (disp_src(k) / 60) % 60;
   endfunction

   // Cycle-by-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("alarm12",    int'(alarm12), int'(alm[0]));
         chk("alarm_idx12", int'(idx12),  idx[0]);
         chk("hr_MSB12",   int'(hm12), exp_hr(0) / 10);
         chk("hr_LSB12",   int'(hl12), exp_hr(0) % 10);
         chk("min_MSB12",  int'(mm12), exp_min(0) / 10);
         chk("min_LSB12",  int'(ml12), exp_min(0) % 10);
         chk("sec_tick12", int'(tick12), int'(((mode == 2'b00) || (mode == 2'b11)) && pc == TD - 1));
         chk("alarm24",    int'(alarm24), int'(alm[1]));
         chk("alarm_idx24", int'(idx24),  idx[1]);
         chk("hr_MSB24",   int'(hm24), exp_hr(1) / 10);
         chk("hr_LSB24",   int'(hl24), exp_hr(1) % 10);
         chk("min_MSB24",  int'(mm24), exp_min(1) / 10);
         chk("min_LSB24",  int'(ml24), exp_min(1) % 10);
         chk("sec_tick24", int'(tick24), int'(((mode == 2'b00) || (mode == 2'b11)) && pc == TD - 1));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         if (which == 0) min_up = 1'b1; else if (which == 1) hour_up = 1'b1; else snooze = 1'b1;
         step(2);
         min_up = 1'b0; hour_up = 1'b0; snooze = 1'b0;
         step(2);
      end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step(1);
      clr = 1'b0;
   endtask

   // Waits (bounded) for the chosen instance to ring; returns at that negedge.
   task automatic wait_alarm(input int k, input int budget, input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((k == 0 && alarm12) || (k == 1 && alarm24)) begin
            ok = 1'b1;
            break;
         end
      end
      chk(nm, int'(ok), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, ev;
      bit seen;
      clr = 1'b1; mode = 2'b00; alarm_sel = 2'd0; alarm_en = 4'b0000;
      min_up = 1'b0; hour_up = 1'b0; snooze = 1'b0;
      step(2);
      @(negedge clk);
      chk("rst_hr_MSB12", int'(hm12), 1);
      chk("rst_hr_LSB12", int'(hl12), 2);
      chk("rst_hr24",     int'(hm24) * 10 + int'(hl24), 0);
      chk("rst_min12",    int'(mm12) * 10 + int'(ml12), 0);
      chk("rst_alarm",    int'(alarm12), 0);
      clr = 1'b0;

      // sec_tick spacing in run mode
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (tick12) begin seen = 1'b1; break; end
      end
      chk("tick_seen", int'(seen), 1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n++;
         if (tick12) break;
      end
      chk("tick_period", n, 4);

      // Full day of hour rollovers: set HH:59, run one minute, check hour.
      for (int h = 0; h < 24; h++) begin
         mode = 2'b10;
         pulse(0, 59);
         mode = 2'b00;
         step(242);
         @(negedge clk);
         ev = ((h + 1) % 12 == 0) ? 12 : (h + 1) % 12;
         chk("day_hr12", int'(hm12) * 10 + int'(hl12), ev);
         chk("day_hr24", int'(hm24) * 10 + int'(hl24), (h + 1) % 24);
         chk("day_min",  int'(mm12) * 10 + int'(ml12), 0);
      end

      // Alarm 2 at 03:30, ring length
      do_clr();
      mode = 2'b01; alarm_sel = 2'd2;
      pulse(1, 3);
      pulse(0, 30);
      mode = 2'b10;
      pulse(1, 3);
      pulse(0, 29);
      alarm_en = 4'b0100;
      mode = 2'b11;
      wait_alarm(0, 300, "ring_0330_timeout");
      chk("ring_0330_idx", int'(idx12), 2);
      chk("ring_0330_hr",  int'(hm12) * 10 + int'(hl12), 3);
      chk("ring_0330_min", int'(mm12) * 10 + int'(ml12), 30);
      n = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (alarm12) n++; else break;
      end
      chk("ring_len_cycles", n, RS * TD);

      // Two alarms at 01:00: lowest index wins; clearing its enable silences it
      do_clr();
      mode = 2'b01; alarm_sel = 2'd0;
      pulse(1, 1);
      alarm_sel = 2'd1;
      pulse(1, 1);
      mode = 2'b10;
      pulse(0, 59);
      alarm_en = 4'b0011;
      mode = 2'b11;
      wait_alarm(0, 300, "ring_0100_timeout");
      chk("ring_0100_idx", int'(idx12), 0);
      chk("ring_0100_hr",  int'(hm12) * 10 + int'(hl12), 1);
      alarm_en = 4'b0010;
      @(negedge clk);
      chk("en_clear_alarm", int'(alarm12), 0);

      // Snooze at 23:58 re-rings at 00:03 (24 h) / 12:03 (12 h)
      do_clr();
      mode = 2'b01; alarm_sel = 2'd0;
      pulse(1, 23);
      pulse(0, 58);
      mode = 2'b10;
      pulse(1, 23);
      pulse(0, 57);
      alarm_en = 4'b0001;
      mode = 2'b11;
      wait_alarm(1, 300, "ring_2358_timeout");
      chk("ring_2358_hr24",  int'(hm24) * 10 + int'(hl24), 23);
      chk("ring_2358_min24", int'(mm24) * 10 + int'(ml24), 58);
      pulse(2, 1);
      @(negedge clk);
      chk("snoozed_alarm24", int'(alarm24), 0);
      wait_alarm(1, 1400, "rering_timeout");
      chk("rering_hr24",  int'(hm24) * 10 + int'(hl24), 0);
      chk("rering_min24", int'(mm24) * 10 + int'(ml24), 3);
      chk("rering_hr12",  int'(hm12) * 10 + int'(hl12), 12);
      chk("rering_alarm12", int'(alarm12), 1);

      // Clear while ringing
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("clr_ring_alarm12", int'(alarm12), 0);
      chk("clr_ring_alarm24", int'(alarm24), 0);
      chk("clr_ring_hr12",  int'(hm12) * 10 + int'(hl12), 12);
      chk("clr_ring_min12", int'(mm12) * 10 + int'(ml12), 0);
      clr = 1'b0;
      mode = 2'b10;
      step(2);

      // Held min_up gives exactly one increment
      min_up = 1'b1;
      step(100);
      min_up = 1'b0;
      step(3);
      @(negedge clk);
      chk("hold_min12", int'(mm12) * 10 + int'(ml12), 1);
      chk("hold_hr12",  int'(hm12) * 10 + int'(hl12), 12);

      step(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1_666_666, clk cycles per one-second tick.
REQ-002 SHALL have parameter NUM_ALARMS, default 4, number of independent alarm registers (1..8).
REQ-003 SHALL have parameter HOUR24, default 0: 0 = 12-hour display (1..12), 1 = 24-hour (0..23).
REQ-004 SHALL have parameter RING_SECS, default 5, alarm output duration in ticks.
REQ-005 SHALL have parameter SNOOZE_MINS, default 5, snooze delay in minutes.
REQ-006 SHALL have port clk  in  1  system clock, single clock domain.
REQ-007 SHALL have port clr  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port mode  in  2  00 run, 01 set alarm, 10 set time, 11 run with alarms armed.
REQ-009 SHALL have port alarm_sel  in  $clog2(NUM_ALARMS) (min 1)  alarm index edited and displayed in mode 01.
REQ-010 SHALL have port min_up  in  1  level input; each rising edge increments minutes of the edited target.
REQ-011 SHALL have port hour_up  in  1  level input; each rising edge increments hours of the edited target.
REQ-012 SHALL have port alarm_en  in  NUM_ALARMS  per-alarm enable.
REQ-013 SHALL have port snooze  in  1  level input; rising edge snoozes a ringing alarm.
REQ-014 SHALL have port alarm  out  1  ringing indicator.
REQ-015 SHALL have port alarm_idx  out  $clog2(NUM_ALARMS) (min 1)  index of the ringing/snoozed alarm.
REQ-016 SHALL have ports min_LSB, min_MSB, hr_LSB, hr_MSB  out  4 each  BCD display digits.
REQ-017 SHALL have port sec_tick  out  1  one-cycle pulse per one-second tick.

Function
REQ-018 SHALL generate sec_tick when the prescaler reaches TICK_DIV-1, then restart at 0; the prescaler is held at 0 in modes 01 and 10.
REQ-019 SHALL advance seconds 0..59 on each tick in modes 00/11; at 59->0 minutes advance 0..59; at minute 59->0 hours advance.
REQ-020 SHALL wrap hours 23->0 when HOUR24=1; when HOUR24=0, hours SHALL count 12,1,2..11,12 and never reach 0.
REQ-021 SHALL detect min_up/hour_up/snooze edges with a one-flop delay; the target register updates on the cycle after the edge is registered; a held level SHALL give exactly one increment.
REQ-022 In mode 10, edges SHALL set the time registers and clear seconds to 0 on every min_up edge; minutes wrap 59->0 without carrying into hours.
REQ-023 In mode 01, edges SHALL edit alarm[alarm_sel] with the same wrap rules; the other alarms are unchanged.
REQ-024 The display SHALL show alarm[alarm_sel] in mode 01 and the time in all other modes, converted combinationally.
REQ-025 The alarm FSM SHALL have states IDLE, RING, SNOOZE.
REQ-026 IDLE->RING: in mode 11, on the tick where seconds becomes 0 and the time equals an enabled alarm; the lowest matching index wins and is latched into alarm_idx.
REQ-027 RING: alarm=1; it counts ticks; after RING_SECS ticks it returns to IDLE.
REQ-028 RING->SNOOZE: on a snooze edge; the wake time is latched as current time + SNOOZE_MINS with hour and day wrap.
REQ-029 SNOOZE->RING: when the time equals the wake time at seconds 0; the ring counter restarts.
REQ-030 Leaving mode 11, or clearing alarm_en[alarm_idx], SHALL force IDLE with alarm=0 in the next cycle.
REQ-031 A match while in RING or SNOOZE SHALL be ignored.
REQ-032 alarm SHALL be a registered output, asserted in the cycle after the RING entry condition is met.

Reset
REQ-033 clr SHALL zero the prescaler, seconds, minutes, edge flops, ring counter, alarm and alarm_idx, and force FSM IDLE.
REQ-034 clr SHALL set hours to 12 (HOUR24=0) or 0 (HOUR24=1); all alarm registers SHALL reset to that hour with minute 00.
REQ-035 clr SHALL take priority over every other input in the same cycle, including mid-RING and mid-SNOOZE.

Structure
REQ-036 The FSM state encodings, mode codes and the SEC_MAX/MIN_MAX constants SHALL live in shared package clock_pkg.
REQ-037 The existing binarytoBCD SHALL be instantiated once for the display path, fed by a mode-selected minutes/hours mux.
REQ-038 Alarm registers SHALL be arrays indexed by parameter, not unrolled.

Verification (TICK_DIV=4)
REQ-039 clr, then run 24 h with HOUR24=0: the hour sequence SHALL be 12,1..11,12; sec_tick SHALL pulse every 4 cycles.
REQ-040 Mode 01, alarm_sel=2, 3 hour_up and 30 min_up pulses, mode 11, alarm_en=0100: alarm SHALL rise at 03:30:00, alarm_idx=2, and stay high for exactly 5 ticks.
REQ-041 Alarms 0 and 1 both at 01:00 and enabled: alarm_idx SHALL be 0.
REQ-042 Snooze at 23:58 with SNOOZE_MINS=5: alarm SHALL re-ring at 00:03:00 (HOUR24=1).
REQ-043 Holding min_up high for 100 cycles SHALL give exactly +1 minute.
REQ-044 clr asserted during RING: alarm=0 and time SHALL read 12:00 on the next cycle.
